// File: rtl/wavetable_writer_if.sv
// wavetable_writer_if: bundles the host byte stream, the wavetable RAM write
// port and the frame status flags of wavetable_writer.
//   IN_DATA/IN_VALID/IN_READY : byte stream from the host link
//   ABORT                     : synchronous frame abort
//   WE/WA/WD                  : RAM write port, WA = {program, index}
//   BUSY/DONE/ERR             : frame in progress / good / bad checksum pulses
// modport slave  : the writer block
// modport master : the byte source that also observes the RAM port and status
interface wavetable_writer_if #(
    parameter int PROG_W = 7,
    parameter int IDX_W  = 6,
    parameter int DATA_W = 8
);
    logic [7:0]              IN_DATA;
    logic                    IN_VALID;
    logic                    IN_READY;
    logic                    ABORT;
    logic                    WE;
    logic [PROG_W+IDX_W-1:0] WA;
    logic [DATA_W-1:0]       WD;
    logic                    BUSY;
    logic                    DONE;
    logic                    ERR;

    modport slave (
        input  IN_DATA, IN_VALID, ABORT,
        output IN_READY, WE, WA, WD, BUSY, DONE, ERR
    );

    modport master (
        output IN_DATA, IN_VALID, ABORT,
        input  IN_READY, WE, WA, WD, BUSY, DONE, ERR
    );
endinterface

// File: rtl/wavetable_writer.sv
// wavetable_writer: receives one framed upload (program byte, 64 sample bytes,
// XOR checksum byte) and writes the samples into the wavetable RAM at
// {program, index}. Writes are committed as they arrive; the checksum result
// is reported as a one-cycle DONE or ERR pulse.
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : wavetable_writer_if.slave (stream in, RAM write port, status)
module wavetable_writer #(
    parameter int PROG_W = 7,
    parameter int IDX_W  = 6,
    parameter int DATA_W = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    wavetable_writer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_CHECK,
        S_RESULT
    } state_t;

    state_t                  state_q, state_d;
    logic [PROG_W-1:0]       prog_q, prog_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              acc_q, acc_d;
    logic                    match_q, match_d;
    logic                    we_q, we_d;
    logic [PROG_W+IDX_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0]       wd_q, wd_d;
    logic                    accept;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            prog_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            match_q <= 1'b0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            match_q <= match_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    // RESULT is the only state that refuses bytes.
    assign accept = bus.IN_VALID && (state_q != S_RESULT);

    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        match_d = match_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;

        // Abort beats a byte accepted on the same edge; in IDLE it is ignored.
        if (bus.ABORT && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Bytes with bit7 set are resync filler and are dropped.
                    if (accept && !bus.IN_DATA[7]) begin
                        prog_d  = bus.IN_DATA[PROG_W-1:0];
                        idx_d   = '0;
                        acc_d   = bus.IN_DATA;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        we_d  = 1'b1;
                        wa_d  = {prog_q, idx_q};
                        wd_d  = bus.IN_DATA[DATA_W-1:0];
                        acc_d = acc_q ^ bus.IN_DATA;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == '1) begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        match_d = (bus.IN_DATA == acc_q);
                        state_d = S_RESULT;
                    end
                end
                S_RESULT: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.IN_READY = (state_q != S_RESULT);
    assign bus.BUSY     = (state_q != S_IDLE);
    assign bus.DONE     = (state_q == S_RESULT) && match_q;
    assign bus.ERR      = (state_q == S_RESULT) && !match_q;
    assign bus.WE       = we_q;
    assign bus.WA       = wa_q;
    assign bus.WD       = wd_q;

endmodule

// File: tb/tb_wavetable_writer.sv
// tb_wavetable_writer: drives framed uploads (table of frame scenarios plus
// hand-written corner sequences) and compares the RAM writes and status pulses
// against expectations computed from the frame contents.
module tb_wavetable_writer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wavetable_writer_if #(.PROG_W(7), .IDX_W(6), .DATA_W(8)) bus ();

    wavetable_writer #(.PROG_W(7), .IDX_W(6), .DATA_W(8)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int failed = 0;

    // Monitor: records every RAM write and status pulse at the falling edge.
    int obs_wa[$];
    int obs_wd[$];
    int obs_cyc[$];
    int n_done = 0;
    int n_err = 0;
    int cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.WE) begin
                obs_wa.push_back(int'(bus.WA));
                obs_wd.push_back(int'(bus.WD));
                obs_cyc.push_back(cyc);
            end
            if (bus.DONE) n_done++;
            if (bus.ERR) n_err++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one byte after optional random idle cycles; returns in the cycle
    // following the edge that accepted it.
    task automatic send(input logic [7:0] b, input int gap_pct);
        int guard;
        while ($urandom_range(99) < gap_pct) begin
            bus.IN_VALID = 1'b0;
            tick();
        end
        bus.IN_DATA  = b;
        bus.IN_VALID = 1'b1;
        guard = 0;
        while (!bus.IN_READY && guard < 10) begin
            tick();
            guard++;
        end
        if (guard >= 10) check("ready_timeout", 0, 1);
        tick();
        bus.IN_VALID = 1'b0;
    endtask

    typedef struct {
        int         prog;      // -1 selects a random program
        bit         ramp;      // samples = index, else random
        logic [7:0] ck_mask;   // XORed into the correct checksum
        int         gap;       // percent chance of an idle cycle before a byte
        int         abort_at;  // sample index carrying ABORT, 64 = none
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    vec_t tbl[7];

    task automatic run_frame(input vec_t v);
        int p;
        int nexp;
        int base;
        int d0;
        int e0;
        int nobs;
        logic [7:0] s[64];
        logic [7:0] ck;
        p = (v.prog < 0) ? int'($urandom_range(127)) : v.prog;
        for (int i = 0; i < 64; i++) s[i] = v.ramp ? 8'(i) : 8'($urandom_range(255));
        ck = 8'(p);
        for (int i = 0; i < 64; i++) ck ^= s[i];
        ck ^= v.ck_mask;
        nexp = (v.abort_at < 64) ? v.abort_at : 64;
        base = obs_wa.size();
        d0 = n_done;
        e0 = n_err;

        send(8'(p), v.gap);
        check("busy_after_prog", int'(bus.BUSY), 1);
        for (int i = 0; i < nexp; i++) send(s[i], v.gap);
        if (v.abort_at < 64) begin
            bus.IN_DATA  = s[v.abort_at];
            bus.IN_VALID = 1'b1;
            bus.ABORT    = 1'b1;
            tick();
            bus.ABORT    = 1'b0;
            bus.IN_VALID = 1'b0;
            check("busy_after_abort", int'(bus.BUSY), 0);
        end else begin
            send(ck, v.gap);
            check("done_pulse", int'(bus.DONE), int'(v.exp_done));
            check("err_pulse", int'(bus.ERR), int'(v.exp_err));
            check("ready_in_result", int'(bus.IN_READY), 0);
            check("busy_in_result", int'(bus.BUSY), 1);
            tick();
            check("ready_after_result", int'(bus.IN_READY), 1);
            check("busy_after_result", int'(bus.BUSY), 0);
            check("done_one_cycle", int'(bus.DONE), 0);
        end
        repeat (3) tick();

        nobs = obs_wa.size() - base;
        check("write_count", nobs, nexp);
        for (int i = 0; i < nexp && i < nobs; i++) begin
            check("wa", obs_wa[base+i], p * 64 + i);
            check("wd", obs_wd[base+i], int'(s[i]));
        end
        if (v.gap == 0 && nexp == 64 && nobs >= 64)
            check("we_consecutive", obs_cyc[base+63] - obs_cyc[base], 63);
        check("done_count", n_done - d0, int'(v.exp_done));
        check("err_count", n_err - e0, int'(v.exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int d0;
        int e0;

        tbl[0] = '{5,   1'b1, 8'h00, 0,  64, 1'b1, 1'b0};
        tbl[1] = '{5,   1'b1, 8'h03, 0,  64, 1'b0, 1'b1};
        tbl[2] = '{5,   1'b1, 8'h00, 0,  64, 1'b1, 1'b0};
        tbl[3] = '{5,   1'b1, 8'h00, 0,  10, 1'b0, 1'b0};
        tbl[4] = '{127, 1'b1, 8'h00, 0,  64, 1'b1, 1'b0};
        tbl[5] = '{5,   1'b1, 8'h00, 50, 64, 1'b1, 1'b0};
        tbl[6] = '{-1,  1'b0, 8'h80, 30, 64, 1'b0, 1'b1};

        bus.IN_DATA  = '0;
        bus.IN_VALID = 1'b0;
        bus.ABORT    = 1'b0;

        #12;
        check("rst_we", int'(bus.WE), 0);
        check("rst_wa", int'(bus.WA), 0);
        check("rst_wd", int'(bus.WD), 0);
        check("rst_busy", int'(bus.BUSY), 0);
        check("rst_done", int'(bus.DONE), 0);
        check("rst_err", int'(bus.ERR), 0);
        check("rst_ready", int'(bus.IN_READY), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 7; t++) run_frame(tbl[t]);

        // Resync filler in IDLE is silently discarded.
        b0 = obs_wa.size();
        d0 = n_done;
        e0 = n_err;
        send(8'h80, 0);
        check("resync_busy_80", int'(bus.BUSY), 0);
        send(8'hFF, 0);
        check("resync_busy_ff", int'(bus.BUSY), 0);
        repeat (2) tick();
        check("resync_writes", obs_wa.size() - b0, 0);
        check("resync_done", n_done - d0, 0);
        check("resync_err", n_err - e0, 0);
        run_frame(tbl[0]);

        // ABORT in IDLE does not stop a program byte from starting a frame.
        bus.ABORT = 1'b1;
        send(8'h03, 0);
        bus.ABORT = 1'b0;
        check("abort_idle_busy", int'(bus.BUSY), 1);
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        check("abort_exit_busy", int'(bus.BUSY), 0);

        // Reset mid-frame right after sample 30 is accepted.
        send(8'h09, 0);
        for (int i = 0; i <= 30; i++) send(8'(i + 100), 0);
        rst_n = 1'b0;
        #1;
        check("midrst_we", int'(bus.WE), 0);
        check("midrst_wa", int'(bus.WA), 0);
        check("midrst_wd", int'(bus.WD), 0);
        check("midrst_busy", int'(bus.BUSY), 0);
        check("midrst_done", int'(bus.DONE), 0);
        check("midrst_err", int'(bus.ERR), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("midrst_ready", int'(bus.IN_READY), 1);
        run_frame(tbl[4]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
